// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
`timescale 1ns/1ps
package inst_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
`timescale 1ns/1ps
interface inst_loader_if #(
  parameter int ADDR_W = 6
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // master: stream source that also observes the memory writes
  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
`timescale 1ns/1ps
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic        word_full,
  output logic [31:0] word_nxt
);

  logic [1:0]  cnt;
  logic [31:0] word;

  // Word as it will look once din is merged at the current byte lane
  always_comb begin
    word_nxt            = word;
    word_nxt[8*cnt +: 8] = din;
  end

  // High on the load that completes the word; word_nxt then holds all 4 bytes
  assign word_full = load && (cnt == 2'(BYTES_PER_WORD - 1));

  // Byte counter and partial-word register; counter wraps naturally after 4 loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (load) begin
      cnt  <= cnt + 2'd1;
      word <= word_nxt;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: takes LEN (16-bit LE) then LEN little-endian words, writes them to
// instruction memory from address 0, then releases the CPU reset.
`timescale 1ns/1ps
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_loader_if.slave    bus,
  output logic            cpu_rst_n,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [15:0]       len_nxt;
  logic [ADDR_W-1:0] idx;
  logic              in_ready_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   words_q;

  logic              acc;
  logic              pk_load;
  logic              pk_clr;
  logic              pk_full;
  logic [31:0]       pk_word;
  logic              last_word;

  assign acc       = bus.in_valid & in_ready_q;
  assign len_nxt   = {bus.in_data, len_lo};
  assign pk_load   = acc && (state == DATA);
  // Fresh word at the start of the image and after every write
  assign pk_clr    = (state == WRITE) || ((state == LEN_HI) && acc);
  assign last_word = ({{(16-ADDR_W){1'b0}}, idx} == (len - 16'd1));

  inst_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .load      (pk_load),
    .din       (bus.in_data),
    .word_full (pk_full),
    .word_nxt  (pk_word)
  );

  // Load FSM; every output is registered and set on the edge entering its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LEN_LO;
      len_lo     <= '0;
      len        <= '0;
      idx        <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      im_we_q <= 1'b0;
      case (state)
        LEN_LO: begin
          in_ready_q <= 1'b1;
          if (acc) begin
            len_lo <= bus.in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (acc) begin
            len <= len_nxt;
            if (len_nxt == 16'd0) begin
              state      <= RUN;
              in_ready_q <= 1'b0;
              cpu_rst_q  <= 1'b1;
              done_q     <= 1'b1;
            end else if (len_nxt > 16'(DEPTH)) begin
              state      <= ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (pk_full) begin
            state      <= WRITE;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b1;
            im_addr_q  <= idx;
            im_wdata_q <= pk_word;
          end
        end
        WRITE: begin
          words_q <= words_q + 1'b1;
          if (last_word) begin
            state     <= RUN;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            idx        <= idx + 1'b1;
            state      <= DATA;
            in_ready_q <= 1'b1;
          end
        end
        RUN, ERR: in_ready_q <= 1'b0;
        default:  state      <= LEN_LO;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign cpu_rst_n     = cpu_rst_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: full-rate, gapped, empty, overflow, max-size and mid-load reset.
`timescale 1ns/1ps
module tb_inst_loader;

  localparam int ADDR_W = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cpu_rst_n;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cpu_rst_n    (cpu_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and cpu_rst_n rise log, sampled mid-cycle
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];
  int                rise_q[$];
  int                acc_q[$];
  logic              cpu_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.im_we) begin
      wa_q.push_back(bus.im_addr);
      wd_q.push_back(bus.im_wdata);
      wc_q.push_back(cyc);
    end
    if (cpu_rst_n && !cpu_prev) rise_q.push_back(cyc);
    cpu_prev = cpu_rst_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte after `gap` idle cycles; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 64'(t), 64'd0);
    acc_q.push_back(cyc);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b;
    int n;
    logic [7:0] k;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // ---- reset state ----
    repeat (10) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_addr", bus.im_addr, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_words", words_loaded, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_cpu_rst_n", cpu_rst_n, 0);
    check("idle_no_write", 64'(wa_q.size()), 0);

    // ---- full-rate two-word load ----
    b = wa_q.size();
    n = acc_q.size();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    repeat (3) @(negedge clk);
    check("fr_nwrites", 64'(wa_q.size() - b), 2);
    check("fr_addr0", wa_q[b], 0);
    check("fr_data0", wd_q[b], 32'h0000_0013);
    check("fr_addr1", wa_q[b+1], 1);
    check("fr_data1", wd_q[b+1], 32'h0010_0093);
    check("fr_we_latency", 64'(wc_q[b] - acc_q[n+5]), 1);
    check("fr_throughput", 64'(wc_q[b+1] - wc_q[b]), 5);
    check("fr_rise_timing", 64'(rise_q[$] - wc_q[b+1]), 1);
    check("fr_cpu_rst_n", cpu_rst_n, 1);
    check("fr_done", load_done, 1);
    check("fr_err", load_err, 0);
    check("fr_words", words_loaded, 2);
    check("fr_in_ready", bus.in_ready, 0);
    check("fr_we_idle", bus.im_we, 0);
    check("fr_wdata_hold", bus.im_wdata, 32'h0010_0093);

    // ---- empty image ----
    do_reset(3);
    b = wa_q.size();
    send(8'h00, 0); send(8'h00, 0);
    repeat (3) @(negedge clk);
    check("len0_nwrites", 64'(wa_q.size() - b), 0);
    check("len0_rise_timing", 64'(rise_q[$] - acc_q[$]), 1);
    check("len0_done", load_done, 1);
    check("len0_words", words_loaded, 0);

    // ---- overflow: LEN = DEPTH+1 ----
    do_reset(3);
    b = wa_q.size();
    send(8'h41, 0); send(8'h00, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    n = 0;
    repeat (10) begin
      if (bus.in_ready) n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("err_flag", load_err, 1);
    check("err_cpu_rst_n", cpu_rst_n, 0);
    check("err_done", load_done, 0);
    check("err_in_ready", bus.in_ready, 0);
    check("err_no_accept", 64'(n), 0);
    check("err_nwrites", 64'(wa_q.size() - b), 0);

    // ---- max-size image: LEN = DEPTH ----
    do_reset(3);
    b = wa_q.size();
    send(8'h40, 0); send(8'h00, 0);
    for (int i = 0; i < 64; i++) begin
      k = 8'(i);
      send(k, 0); send(k + 8'd1, 0); send(k + 8'd2, 0); send(k + 8'd3, 0);
    end
    repeat (3) @(negedge clk);
    check("max_nwrites", 64'(wa_q.size() - b), 64);
    check("max_data0", wd_q[b], 32'h0302_0100);
    check("max_addr32", wa_q[b+32], 32);
    check("max_last_addr", wa_q[b+63], 63);
    check("max_last_data", wd_q[b+63], 32'h4241_403F);
    check("max_words", words_loaded, 64);
    check("max_done", load_done, 1);
    check("max_err", load_err, 0);

    // ---- gapped stream with 20-cycle stalls inside words ----
    do_reset(3);
    b = wa_q.size();
    send(8'h02, 1); send(8'h00, 2);
    send(8'h13, 0); send(8'h00, 3); send(8'h00, 20); send(8'h00, 1);
    send(8'h93, 2); send(8'h00, 0); send(8'h10, 20); send(8'h00, 3);
    repeat (3) @(negedge clk);
    check("gap_nwrites", 64'(wa_q.size() - b), 2);
    check("gap_data0", wd_q[b], 32'h0000_0013);
    check("gap_data1", wd_q[b+1], 32'h0010_0093);
    check("gap_addr1", wa_q[b+1], 1);
    check("gap_words", words_loaded, 2);
    check("gap_done", load_done, 1);

    // ---- reset during 3rd byte of word 1, then fresh load ----
    do_reset(3);
    b = wa_q.size();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h00, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h10;
    #2 rst_n = 1'b0;
    #1;
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_words", words_loaded, 0);
    check("mid_wdata", bus.im_wdata, 0);
    check("mid_cpu_rst_n", cpu_rst_n, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_nwrites", 64'(wa_q.size() - b), 1);
    b = wa_q.size();
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    repeat (3) @(negedge clk);
    check("fresh_nwrites", 64'(wa_q.size() - b), 1);
    check("fresh_addr", wa_q[b], 0);
    check("fresh_data", wd_q[b], 32'hDEAD_BEEF);
    check("fresh_words", words_loaded, 1);
    check("fresh_done", load_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time instruction-memory loader upstream of the single-cycle CPU Mainboard.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word into instruction memory, then releases the CPU's reset so execution starts at pc 0 with the loaded program.
- The CPU is held in reset for the whole load, so pc/inst never advance on a partially loaded image.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  word address of the write.
- im_wdata  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the CPU Mainboard; 1 = run.
- load_done  output  1  image fully written, CPU running.
- load_err  output  1  length exceeded DEPTH; load aborted.
- words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Clocking and reset:
  - One clock; Reset is asynchronous and active-low.
  - While Reset=0: state=LEN_LO, all outputs 0 (in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, load_done=0, load_err=0, words_loaded=0), length, byte and word counters cleared.
  - Reset asserted mid-load aborts immediately. The CPU stays in reset; memory contents already written are not cleared.
- Handshake:
  - A byte is consumed on a rising edge where in_valid & in_ready.
  - in_ready is a registered function of state: 1 in LEN_LO, LEN_HI, DATA; 0 elsewhere.
  - in_valid with in_ready=0 is ignored; no byte is lost or counted.
- Stream format: LEN[7:0], LEN[15:8], then LEN words of 4 bytes each, least-significant byte first.
- FSM states:
  - LEN_LO: on accept, latch LEN low byte -> LEN_HI.
  - LEN_HI: on accept, latch high byte, then:
    - LEN==0 -> RUN.
    - LEN > DEPTH -> ERR.
    - else -> DATA with byte counter 0, word index 0.
  - DATA: on each accept, shift the byte into word bits [8*k+7:8*k] (k = byte counter 0..3) and increment k. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - im_we=1, im_addr=word index, im_wdata=assembled word.
    - words_loaded increments at end of cycle.
    - If index==LEN-1 -> RUN; else index+1, k=0 -> DATA.
  - RUN (terminal): cpu_rst_n=1, load_done=1, im_we=0, in_ready=0. Remains until Reset.
  - ERR (terminal): load_err=1, cpu_rst_n=0, in_ready=0. Remains until Reset.
- Timing:
  - The write strobe appears in the cycle immediately after the 4th byte's accept edge.
  - Peak throughput is 5 cycles per word (4 accepts + 1 write bubble).
  - cpu_rst_n and load_done rise on the edge ending the final WRITE (or the LEN_HI accept edge when LEN==0).
  - The CPU's first instruction-fetch cycle follows that edge.
- Boundaries:
  - LEN==DEPTH is legal; the last write uses im_addr = DEPTH-1, with no wrap.
  - LEN==DEPTH+1 -> ERR with no writes.
  - in_valid gaps of any length in DATA hold the partial word.
  - im_addr and im_wdata hold their last value when im_we=0.

Decomposition:
- Shared package: FSM state encoding (LEN_LO, LEN_HI, DATA, WRITE, RUN, ERR) and the byte-per-word constant 4.
- One natural sub-module, byte_packer: 2-bit byte counter plus 32-bit little-endian shift/assemble register, with load/clear inputs and a word_full output.
- The FSM stays in inst_loader.

Test Plan:
- Reset=0 for 100 ns then 1; no in_valid -> in_ready=1, cpu_rst_n=0, im_we never asserts.
- Stream 02 00, 13 00 00 00, 93 00 10 00 at full rate -> im_we pulses with (addr 0, 0x00000013) then (addr 1, 0x00100093); cpu_rst_n=1 and load_done=1 one edge after the second write; words_loaded=2.
- Stream 00 00 -> no writes; cpu_rst_n=1 one edge after the second byte.
- ADDR_W=6, stream 41 00 -> load_err=1, cpu_rst_n stays 0, in_ready=0. Also stream 40 00 plus 64 words -> last write at addr 63, then RUN.
- Random in_valid gaps, including 20-cycle stalls between bytes of one word -> written data identical to the full-rate case; in_valid during WRITE is not consumed.
- Reset pulsed low during the 3rd byte of word 1 -> outputs return to 0 asynchronously; a subsequent fresh stream loads correctly from addr 0.
